// File: rtl/log2_approx.sv
// Pipelined Mitchell log2 approximation with valid/ready on both sides.
// Optional LOG2_MITCHELL_CORR_EN adds a third stage with a quadratic fraction correction.

module lopd #(
  parameter int D_W = 32,
  parameter int P_W = $clog2(D_W)
) (
  input  logic [D_W-1:0] data,
  output logic [P_W-1:0] pos
);
  // Highest set bit wins; an all-zero operand reports position 0.
  always_comb begin
    pos = '0;
    for (int i = 0; i < D_W; i++)
      if (data[i]) pos = P_W'(i);
  end
endmodule

module log2_approx #(
  parameter int D_W    = 32,
  parameter int FRAC_W = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [D_W-1:0]                in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [$clog2(D_W)+FRAC_W-1:0] out_data,
  output logic                          out_zero
);
  localparam int I_W = $clog2(D_W);

  logic           v1, e1, e2;
  logic [D_W-1:0] d1;
  logic [I_W-1:0] pos, shamt;
  logic [FRAC_W-1:0] frac;
  logic           zero1;

  lopd #(.D_W(D_W), .P_W(I_W)) u_lopd (.data(d1), .pos(pos));

  // Leading one lands on bit D_W-1; the FRAC_W bits just below it are the fraction.
  assign zero1 = (d1 == '0);
  assign shamt = I_W'(D_W-1) - pos;
  assign frac  = FRAC_W'((d1 << shamt) >> (D_W-1-FRAC_W));

  assign e1       = !v1 | e2;
  assign in_ready = e1 & !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      v1 <= 1'b0;
      d1 <= '0;
    end else if (e1) begin
      v1 <= in_valid;
      if (in_valid) d1 <= in_data;
    end
  end

`ifdef LOG2_MITCHELL_CORR_EN
  logic              v2, e3, zero2;
  logic [I_W-1:0]    pos2;
  logic [FRAC_W-1:0] frac2, fcor;
  logic [FRAC_W:0]   comp, sum;

  assign e3 = !out_valid | out_ready;
  assign e2 = !v2 | e3;

  always_ff @(posedge clk) begin
    if (rst) begin
      v2    <= 1'b0;
      pos2  <= '0;
      frac2 <= '0;
      zero2 <= 1'b0;
    end else if (e2) begin
      v2    <= v1;
      pos2  <= pos;
      frac2 <= frac;
      zero2 <= v1 & zero1;
    end
  end

  // frac + frac*(1-frac)/4 in fixed point, saturated to the fraction width.
  assign comp = {1'b1, {FRAC_W{1'b0}}} - {1'b0, frac2};
  assign sum  = {1'b0, frac2}
              + (FRAC_W+1)'(((2*FRAC_W+1)'(frac2) * (2*FRAC_W+1)'(comp)) >> (FRAC_W+2));
  assign fcor = sum[FRAC_W] ? {FRAC_W{1'b1}} : sum[FRAC_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_zero  <= 1'b0;
      out_data  <= '0;
    end else if (e3) begin
      out_valid <= v2;
      out_zero  <= v2 & zero2;
      out_data  <= (v2 && !zero2) ? {pos2, fcor} : '0;
    end
  end
`else
  assign e2 = !out_valid | out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_zero  <= 1'b0;
      out_data  <= '0;
    end else if (e2) begin
      out_valid <= v1;
      out_zero  <= v1 & zero1;
      out_data  <= (v1 && !zero1) ? {pos, frac} : '0;
    end
  end
`endif
endmodule
